icache_fetch_arbiter: RTL
=========================

Name: icache_fetch_arbiter

Overview:
- Shares the single icache request port between NUM_REQ per-thread instruction fetch units.
- Captures each fetch unit's single-cycle request into a one-entry pending slot, then grants slots to the icache round-robin while icache_busy is low.
- Tags each granted request with the requester index in access_id.
- Routes icache responses back to the owning fetch unit by access_id.

Parameters:
- NUM_REQ, 4, number of fetch-unit requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester index carried in access_id. Must be no wider than the access_id field.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_in  input  request_t[NUM_REQ]  per-requester fetch request; only .vld and .addr are used.
- req_busy  output  NUM_REQ  combinational; bit i = pending[i]. Fetch unit i must not assert req_in[i].vld while this bit is high.
- req_flush  input  NUM_REQ  per-requester flush, driven on thread halt; clears the pending slot.
- rsp_out  output  request_t[NUM_REQ]  per-requester response, registered.
- icache_req  output  request_t  registered request to the icache.
- icache_busy  input  1  icache cannot accept a request this cycle.
- icache_rsp  input  request_t  icache response; .access_id holds the requester index.
- err_overflow  output  1  sticky; set when a request arrives at a full slot.
- err_bad_id  output  1  sticky; set when a response carries access_id >= NUM_REQ.
- err_clr  input  1  synchronous clear of both sticky error bits.

Behaviour:
- Reset (async, reset low): pending = 0, slot addresses = 0, rr_ptr = 0, icache_req = 0, rsp_out = 0, err_* = 0. Reset mid-operation discards pending slots and in-flight routing; responses arriving after reset deassertion are still routed by id.
- Capture: at an edge with req_in[i].vld = 1 and pending[i] = 0, set pending[i] = 1 and slot_addr[i] = req_in[i].addr.
- Overflow: at an edge with req_in[i].vld = 1 and pending[i] = 1, drop the request, keep the old slot contents, set err_overflow.
- Exception to overflow: if slot i is granted on that same edge, accept the new request into the slot (slot refill); err_overflow stays clear.
- Arbitration (combinational from registered state): when icache_busy = 0 and any slot is eligible, pick the first eligible index scanning upward from rr_ptr with wrap-around (NUM_REQ-1 -> 0).
  - A slot is eligible when pending[i] = 1 and req_flush[i] = 0.
- Grant (at the edge):
  - icache_req.vld = 1, .addr = slot_addr[g], .access_type = NULL_ACCESS, .access_id = g (zero-extended).
  - All other request fields = 0.
  - pending[g] cleared; rr_ptr = (g + 1) mod NUM_REQ.
- Idle: if there is no grant, icache_req = 0 on the next cycle; icache_req.vld is always a single-cycle pulse per grant.
- Latency: req_in.vld at cycle N -> slot set at N+1 -> earliest icache_req.vld at N+2 (minimum 2 cycles). One grant per cycle at most.
- icache_busy = 1: no grant, slots hold, rr_ptr holds.
- Flush: req_flush[i] clears pending[i] at the next edge.
  - Flush beats grant: a flushed slot is never issued that cycle.
  - Flush together with a new req_in[i].vld: the flush wins and the request is discarded.
- Response routing: at an edge with icache_rsp.vld = 1 and access_id < NUM_REQ:
  - rsp_out[id] = icache_rsp, with .access_id cleared to 0.
  - All other rsp_out = 0.
  - Latency is 1 cycle.
- Bad id: access_id >= NUM_REQ drops the response and sets err_bad_id. Responses for flushed requesters are still routed.
- Errors: err_clr clears both sticky bits at the next edge. If err_clr coincides with a new error event, set wins.

Decomposition:
- Shared package already provides request_t, access types (NULL_ACCESS), and ADDR_FIELD_WIDTH.
- Add to the package: ICACHE_ARB_MAX_REQ = 16.
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs: request vector, rr_ptr. Outputs: grant_vld, one-hot grant, grant index. Purely combinational priority scan; pointer state stays in the parent.

Test Plan:
- Single request: reset, then req_in[2] vld with addr 0x100 at cycle 5, icache_busy = 0 -> icache_req.vld at cycle 7 with addr 0x100 and access_id 2. req_busy[2] high for cycle 6 only.
- Round-robin: all 4 requesters pulse vld in the same cycle (addrs 0x10/0x20/0x30/0x40), rr_ptr = 0 -> grants 0,1,2,3 on consecutive cycles. A new req[0] pulse arriving during this is granted after 3.
- Backpressure: slots 1 and 3 pending, icache_busy high for 5 cycles -> no icache_req.vld, slots and rr_ptr held. Busy drops -> grant 1, then 3.
- Flush vs grant: slot 0 pending, req_flush[0] asserted in the cycle it would be granted -> no issue, pending[0] = 0, next eligible slot granted instead.
- Response routing: icache_rsp with vld, access_id = 3, data = 0xDEADBEEF_CAFEF00D -> rsp_out[3].data equal one cycle later, other rsp_out zero. access_id = 5 -> dropped, err_bad_id = 1, cleared by err_clr.
- Overflow and refill:
  - req_in[1].vld while pending[1] = 1 and slot 1 not granted that cycle -> err_overflow = 1, original addr issued.
  - req_in[1].vld on slot 1's grant edge -> new addr captured, no error.

Source files
------------

// File: rtl/icache_fetch_arbiter_pkg.sv
// Shared icache request types and arbiter limits.
package icache_fetch_arbiter_pkg;

    localparam int ADDR_FIELD_WIDTH   = 32;
    localparam int DATA_FIELD_WIDTH   = 64;
    localparam int ACCESS_ID_WIDTH    = 8;
    localparam int ICACHE_ARB_MAX_REQ = 16;

    typedef enum logic [1:0] {
        NULL_ACCESS     = 2'd0,
        READ_ACCESS     = 2'd1,
        WRITE_ACCESS    = 2'd2,
        PREFETCH_ACCESS = 2'd3
    } access_type_t;

    typedef struct packed {
        logic                        vld;
        access_type_t                access_type;
        logic [ACCESS_ID_WIDTH-1:0]  access_id;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [DATA_FIELD_WIDTH-1:0] data;
    } request_t;

endpackage

// File: rtl/icache_fetch_arbiter_if.sv
// Fetch-unit and icache side bundle of the icache fetch arbiter.
interface icache_fetch_arbiter_if
    import icache_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    request_t [NUM_REQ-1:0] req_in;
    logic     [NUM_REQ-1:0] req_busy;
    logic     [NUM_REQ-1:0] req_flush;
    request_t [NUM_REQ-1:0] rsp_out;
    request_t               icache_req;
    logic                   icache_busy;
    request_t               icache_rsp;

    // Arbiter view
    modport master (
        input  req_in, req_flush, icache_busy, icache_rsp,
        output req_busy, rsp_out, icache_req
    );

    // Environment view (fetch units + icache)
    modport slave (
        output req_in, req_flush, icache_busy, icache_rsp,
        input  req_busy, rsp_out, icache_req
    );

endinterface

// File: rtl/icache_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin priority scan; the pointer lives in the parent.
module rr_arbiter
    import icache_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_vld,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int unsigned N = NUM_REQ;

    // First requesting index at or above rr_ptr, wrapping to 0
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!grant_vld && req[idx]) begin
                grant_vld     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/icache_fetch_arbiter.sv
// Shares one icache request port between NUM_REQ fetch units.
module icache_fetch_arbiter
    import icache_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_fetch_arbiter_if.master bus,
    output logic                   err_overflow,
    output logic                   err_bad_id,
    input  logic                   err_clr
);

    logic [NUM_REQ-1:0]          pending;
    logic [ADDR_FIELD_WIDTH-1:0] slot_addr [NUM_REQ];
    logic [ID_W-1:0]             rr_ptr;
    logic [NUM_REQ-1:0]          arb_req;
    logic [NUM_REQ-1:0]          grant_oh;
    logic                        grant_vld;
    logic [ID_W-1:0]             grant_idx;
    logic                        overflow_evt;
    logic                        bad_id_evt;
    logic                        rsp_id_ok;
    logic [ID_W-1:0]             rsp_idx;
    request_t                    rsp_fwd;
    request_t                    grant_req;
    logic                        unused_bits;

    // Only vld/addr of requests are consumed; the rest is intentionally ignored
    assign unused_bits = ^bus.req_in ^ ^bus.icache_rsp;

    assign bus.req_busy = pending;
    // Flushed slots drop out of arbitration the same cycle they are flushed
    assign arb_req      = bus.icache_busy ? '0 : (pending & ~bus.req_flush);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .rr_ptr    (rr_ptr),
        .grant_vld (grant_vld),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // Overflow: request into a full slot that is neither flushed nor granted
    always_comb begin
        overflow_evt = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_flush[i] && bus.req_in[i].vld && pending[i] && !grant_oh[i]) begin
                overflow_evt = 1'b1;
            end
        end
    end

    // Build the outgoing request and the forwarded response
    always_comb begin
        grant_req             = '0;
        grant_req.vld         = 1'b1;
        grant_req.access_type = NULL_ACCESS;
        grant_req.access_id   = ACCESS_ID_WIDTH'(grant_idx);
        grant_req.addr        = slot_addr[grant_idx];
        rsp_fwd               = bus.icache_rsp;
        rsp_fwd.access_id     = '0;
        rsp_id_ok             = bus.icache_rsp.access_id < ACCESS_ID_WIDTH'(NUM_REQ);
        rsp_idx               = bus.icache_rsp.access_id[ID_W-1:0];
        bad_id_evt            = bus.icache_rsp.vld && !rsp_id_ok;
    end

    // Pending slots: flush wins, a granted slot may refill on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                slot_addr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (bus.req_flush[i]) begin
                    pending[i] <= 1'b0;
                end else if (bus.req_in[i].vld && (!pending[i] || grant_oh[i])) begin
                    pending[i]   <= 1'b1;
                    slot_addr[i] <= bus.req_in[i].addr;
                end else if (grant_oh[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Registered icache request and round-robin pointer advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.icache_req <= '0;
            rr_ptr         <= '0;
        end else if (grant_vld) begin
            bus.icache_req <= grant_req;
            rr_ptr         <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
            bus.icache_req <= '0;
        end
    end

    // Route icache responses to the owning fetch unit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rsp_out <= '0;
        end else begin
            bus.rsp_out <= '0;
            if (bus.icache_rsp.vld && rsp_id_ok) begin
                bus.rsp_out[rsp_idx] <= rsp_fwd;
            end
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_overflow <= 1'b0;
            err_bad_id   <= 1'b0;
        end else begin
            err_overflow <= (err_overflow & ~err_clr) | overflow_evt;
            err_bad_id   <= (err_bad_id & ~err_clr) | bad_id_evt;
        end
    end

endmodule
